// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_pkg - TX state encoding, 8N1 frame constants, width helper. Rev 1.0
// ----------------------------------------------------------------------------
package uart_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// byte_fifo - first-word-fall-through synchronous FIFO, async reset. Rev 1.0
// ----------------------------------------------------------------------------
module byte_fifo
   import uart_tx_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW   = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [AW:0]      level,
   output logic             full,
   output logic             empty
);

   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign level   = wr_ptr - rd_ptr;
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_byte_tx - buffers debug-port bytes and sends them as 8N1 UART. Rev 1.0
// ----------------------------------------------------------------------------
module uart_byte_tx
   import uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16,
   parameter int CNT_W        = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [7:0]                 in_byte,
   input  logic                       in_byte_en,
   output logic                       txd,
   output logic                       busy,
   output logic                       tx_done,
   output logic [clog2(FIFO_DEPTH):0] fifo_level,
   output logic [CNT_W-1:0]           overflow_cnt
);

   localparam int BAUD_W = clog2(CLKS_PER_BIT);
   localparam int BIT_W  = clog2(DATA_BITS);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
   localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   tx_state_t         state, state_n;
   logic [BAUD_W-1:0] baud_cnt, baud_n;
   logic [BIT_W-1:0]  bit_idx, bit_n;
   logic [7:0]        shift, shift_n;
   logic              txd_n;
   logic              pop;
   logic              bit_end;
   logic              drop;
   logic [7:0]        head;
   logic              full;
   logic              empty;

   byte_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (in_byte_en),
      .din   (in_byte),
      .pop   (pop),
      .dout  (head),
      .level (fifo_level),
      .full  (full),
      .empty (empty)
   );

   assign bit_end = (baud_cnt == BAUD_LAST);
   assign drop    = in_byte_en && full && !pop;
   assign busy    = (state != IDLE) || !empty;
   assign tx_done = (state == STOP) && bit_end && (bit_idx == STOP_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         txd      <= 1'b1;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_n;
         bit_idx  <= bit_n;
         shift    <= shift_n;
         txd      <= txd_n;
      end
   end

   always_comb begin
      state_n = state;
      baud_n  = baud_cnt;
      bit_n   = bit_idx;
      shift_n = shift;
      pop     = 1'b0;
      txd_n   = 1'b1;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_n = head;
               baud_n  = '0;
               bit_n   = '0;
               state_n = START;
            end
         end
         START: begin
            if (bit_end) begin
               baud_n  = '0;
               state_n = DATA;
            end else begin
               baud_n = baud_cnt + BAUD_ONE;
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_n  = '0;
               shift_n = shift >> 1;
               if (bit_idx == BIT_LAST) begin
                  bit_n   = '0;
                  state_n = STOP;
               end else begin
                  bit_n = bit_idx + BIT_ONE;
               end
            end else begin
               baud_n = baud_cnt + BAUD_ONE;
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_n = '0;
               if (bit_idx == STOP_LAST) begin
                  bit_n   = '0;
                  state_n = IDLE;
               end else begin
                  bit_n = bit_idx + BIT_ONE;
               end
            end else begin
               baud_n = baud_cnt + BAUD_ONE;
            end
         end
         default: state_n = IDLE;
      endcase
      // txd is registered, so its next value follows the next state.
      case (state_n)
         START:   txd_n = 1'b0;
         DATA:    txd_n = shift_n[0];
         default: txd_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_cnt <= '0;
      end else if (drop && (overflow_cnt != CNT_MAX)) begin
         overflow_cnt <= overflow_cnt + CNT_ONE;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_byte_tx - scoreboard bench: a line decoder checks frames. Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_byte_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    in_byte;
   logic          in_byte_en;
   logic          txd, busy, tx_done;
   logic [LW-1:0] fifo_level;
   logic [7:0]    overflow_cnt;

   logic [7:0]    sat_byte;
   logic          sat_en;
   logic          sat_txd, sat_busy, sat_done;
   logic [LW-1:0] sat_level;
   logic [1:0]    sat_ovf;

   int n_checks = 0;
   int n_fails  = 0;

   logic [7:0] exp_q[$];
   bit  mon_en = 1'b0;
   int  cyc = 0;
   int  start_cyc_last = 0, start_cyc_prev = 0;
   int  done_cnt = 0, done_cyc_last = 0, done_cyc_prev = 0;

   always #5 clk = ~clk;

   uart_byte_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .in_byte(in_byte), .in_byte_en(in_byte_en),
      .txd(txd), .busy(busy), .tx_done(tx_done),
      .fifo_level(fifo_level), .overflow_cnt(overflow_cnt)
   );

   uart_byte_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .in_byte(sat_byte), .in_byte_en(sat_en),
      .txd(sat_txd), .busy(sat_busy), .tx_done(sat_done),
      .fifo_level(sat_level), .overflow_cnt(sat_ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tx_done === 1'b1) begin
         done_cnt      <= done_cnt + 1;
         done_cyc_prev <= done_cyc_last;
         done_cyc_last <= cyc;
      end
   end

   // Line decoder: samples each bit in the middle of its CPB-cycle window.
   initial begin : monitor
      logic [7:0] data;
      forever begin
         @(negedge clk);
         if (mon_en && !reset && txd === 1'b0) begin
            start_cyc_prev = start_cyc_last;
            start_cyc_last = cyc;
            repeat (2) @(negedge clk);
            check("start_bit", txd, 0);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               data[i] = txd;
            end
            repeat (CPB) @(negedge clk);
            check("stop_bit", txd, 1);
            if (exp_q.size() == 0) check("unexpected_frame", {24'd0, data}, 32'hFFFF_FFFF);
            else                   check("frame_data", data, exp_q.pop_front());
         end
      end
   end

   task automatic wait_done(input int target, input int max_cycles, input string tag);
      int n = 0;
      while (done_cnt < target && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_timeout"}, done_cnt >= target, 1);
   endtask

   task automatic push_seq(input logic [7:0] first, input int count);
      for (int i = 0; i < count; i++) begin
         in_byte    = first + 8'(i);
         in_byte_en = 1'b1;
         @(negedge clk);
      end
      in_byte_en = 1'b0;
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got no completion, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int d0;
      bit bad;
      reset = 1'b1; in_byte = '0; in_byte_en = 1'b0; sat_byte = '0; sat_en = 1'b0;

      // Reset idle
      repeat (3) @(negedge clk);
      reset = 1'b0;
      bad = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (txd !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) bad = 1'b1;
      end
      check("idle_line_quiet", bad, 0);
      check("idle_level", fifo_level, 0);
      check("idle_ovf", overflow_cnt, 0);
      check("idle_sat_ovf", sat_ovf, 0);
      check("idle_done_cnt", done_cnt, 0);

      // Single byte 0x55: latency and tx_done/busy timing
      mon_en = 1'b1;
      exp_q.push_back(8'h55);
      in_byte = 8'h55; in_byte_en = 1'b1;
      @(negedge clk);
      in_byte_en = 1'b0;
      check("lat_level_after_e", fifo_level, 1);
      check("lat_txd_still_high", txd, 1);
      @(negedge clk);
      check("txd_fall_e1", txd, 0);
      check("level_after_pop", fifo_level, 0);
      check("busy_in_frame", busy, 1);
      repeat (38) @(negedge clk);
      check("no_early_done", tx_done, 0);
      @(negedge clk);
      check("done_at_e40", tx_done, 1);
      check("busy_at_e40", busy, 1);
      @(negedge clk);
      check("busy_drop_e41", busy, 0);
      check("done_one_cycle", tx_done, 0);
      repeat (3) @(negedge clk);
      check("single_sb_empty", exp_q.size(), 0);

      // Back-to-back 0xA3, 0x0F
      d0 = done_cnt;
      exp_q.push_back(8'hA3);
      exp_q.push_back(8'h0F);
      in_byte = 8'hA3; in_byte_en = 1'b1;
      @(negedge clk);
      in_byte = 8'h0F;
      @(negedge clk);
      in_byte_en = 1'b0;
      wait_done(d0 + 2, 150, "b2b");
      check("b2b_done_spacing", done_cyc_last - done_cyc_prev, 41);
      check("b2b_start_spacing", start_cyc_last - start_cyc_prev, 41);
      repeat (3) @(negedge clk);
      check("b2b_sb_empty", exp_q.size(), 0);

      // Overflow: 7 pushes, 0x06 and 0x07 dropped
      d0 = done_cnt;
      for (int b = 1; b <= 5; b++) exp_q.push_back(8'(b));
      push_seq(8'h01, 7);
      check("ovf_count", overflow_cnt, 2);
      check("ovf_level_full", fifo_level, 4);
      wait_done(d0 + 5, 5 * 41 + 30, "ovf");
      repeat (3) @(negedge clk);
      check("ovf_sb_empty", exp_q.size(), 0);
      check("ovf_busy_clear", busy, 0);

      // Push on the exact IDLE pop cycle with the FIFO full
      d0 = done_cnt;
      for (int b = 16; b <= 21; b++) exp_q.push_back(8'(b));
      push_seq(8'h10, 5);
      bad = 1'b1;
      for (int n = 0; n < 60 && bad; n++) begin
         if (tx_done === 1'b1) bad = 1'b0;
         else @(negedge clk);
      end
      check("simul_find_done", bad, 0);
      @(negedge clk);
      check("simul_level_before", fifo_level, 4);
      in_byte = 8'h15; in_byte_en = 1'b1;
      @(negedge clk);
      in_byte_en = 1'b0;
      check("simul_level_after", fifo_level, 4);
      check("simul_ovf_unchanged", overflow_cnt, 2);
      wait_done(d0 + 6, 6 * 41 + 30, "simul");
      repeat (3) @(negedge clk);
      check("simul_sb_empty", exp_q.size(), 0);

      // Reset mid-frame during DATA bit 3 of 0xFF, two bytes queued
      mon_en = 1'b0;
      push_seq(8'hFF, 1);
      in_byte = 8'h01; in_byte_en = 1'b1;
      @(negedge clk);
      in_byte = 8'h02;
      @(negedge clk);
      in_byte_en = 1'b0;
      repeat (16) @(negedge clk);
      check("pre_rst_busy", busy, 1);
      check("pre_rst_level", fifo_level, 2);
      #2 reset = 1'b1;
      #1;
      check("rst_async_txd", txd, 1);
      check("rst_async_level", fifo_level, 0);
      check("rst_async_busy", busy, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      d0 = done_cnt;
      bad = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (txd !== 1'b1 || busy !== 1'b0) bad = 1'b1;
      end
      check("post_rst_quiet", bad, 0);
      check("post_rst_no_done", done_cnt, d0);
      check("post_rst_level", fifo_level, 0);
      check("post_rst_ovf", overflow_cnt, 0);

      // Reset during a start bit must raise txd before the next edge
      push_seq(8'h00, 1);
      @(negedge clk);
      check("start_low_before_rst", txd, 0);
      #2 reset = 1'b1;
      #1;
      check("rst_async_txd_start", txd, 1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Saturation with CNT_W=2: 15 pushes, 10 drops
      for (int i = 0; i < 15; i++) begin
         sat_byte = 8'(i);
         sat_en   = 1'b1;
         @(negedge clk);
         if (i == 5) check("sat_first_drop", sat_ovf, 1);
      end
      sat_en = 1'b0;
      check("sat_ovf_saturated", sat_ovf, 3);
      check("sat_level_full", sat_level, 4);
      check("final_sb_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
- Downstream consumer of the system's debug byte port (out_byte / out_byte_en pulse at MMIO 0x2000_0000).
- Buffers bytes in a small FIFO and serialises them onto a physical 8N1 UART TX line.
- The firmware's putchar path then reaches real hardware, not only the simulator $write.
- The producer never stalls: bytes arriving while the FIFO is full are dropped and counted.

Parameters:
- CLKS_PER_BIT, 868, clocks per UART bit (100 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 16, byte entries; power of two, >= 2.
- CNT_W, 8, width of the overflow counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_byte  in  8  byte from the system debug port.
- in_byte_en  in  1  one-cycle strobe; in_byte is valid when high.
- txd  out  1  serial output; idles high.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- tx_done  out  1  one-cycle pulse at the end of each stop bit.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow_cnt  out  CNT_W  number of dropped bytes; saturates.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - txd=1, busy=0, tx_done=0, fifo_level=0, overflow_cnt=0.
  - FSM=IDLE; FIFO pointers cleared; baud and bit counters cleared.
  - Any partial frame is abandoned. Its bytes are not resent.
- Push:
  - On a clk edge with in_byte_en=1, the byte is written if level<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - With a simultaneous push and pop, level is unchanged.
  - Otherwise the byte is dropped and overflow_cnt increments, saturating at 2^CNT_W-1.
  - in_byte_en=0 never changes the FIFO.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If level>0: pop the head into an 8-bit shift register, load baud_cnt=0, bit_idx=0, go to START. This is the only pop point.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: txd=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right and increment bit_idx. After bit_idx 7 completes, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. On the final cycle assert tx_done for one cycle and go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps at the end of each bit.
- Latency:
  - in_byte_en sampled at edge E into an empty FIFO in IDLE: level=1 after E.
  - The pop occurs at E+1, and txd falls from E+1 (registered output).
- Frame timing:
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames are separated by exactly one IDLE cycle (txd=1).
- busy = (state!=IDLE) || (level!=0). It is registered or derived combinationally from registers only.
- txd is driven from a flop; no combinational glitches.
- FIFO is first-word-fall-through internally: the head is readable without extra latency.
- Pointer wrap: pointers are $clog2(FIFO_DEPTH)+1 bits; full/empty are derived from the MSB comparison.

Decomposition:
- Package uart_tx_pkg:
  - FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3).
  - Frame constants: DATA_BITS=8, STOP_BITS=1.
  - Function clog2 helper.
- Sub-module byte_fifo:
  - Parameterised synchronous FIFO.
  - Ports: clk, reset, push, din, pop, dout, level, full, empty.
  - uart_byte_tx instantiates one byte_fifo and holds the FSM, baud counter and overflow counter.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted):
- Reset idle: hold reset 3 cycles, release, wait 50 cycles -> txd=1 throughout, busy=0, fifo_level=0, overflow_cnt=0, no tx_done.
- Single byte 0x55, pulse at edge E:
  - fifo_level=1 after E; txd falls at E+1.
  - Sampled bits at mid-bit read 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop).
  - tx_done pulses at E+40; busy drops at E+41.
- Back-to-back 0xA3, 0x0F on consecutive cycles:
  - Two frames decode to 0xA3 then 0x0F.
  - Exactly one txd=1 idle cycle between the stop of frame 1 and the start of frame 2.
  - Two tx_done pulses, 41 cycles apart.
- Overflow: push 7 bytes 0x01..0x07 on consecutive cycles:
  - 0x01 is popped at the second push cycle; the FIFO fills with 0x02..0x05; 0x06 and 0x07 are dropped.
  - overflow_cnt=2; the line carries 0x01..0x05 only.
- Simultaneous push/pop at full: fill the FIFO while idle is blocked, then push on the exact IDLE pop cycle -> byte accepted, level stays 4, overflow_cnt unchanged.
- Reset mid-frame: assert reset during DATA bit 3 of 0xFF with 2 bytes queued:
  - txd=1 asynchronously, before the next clk edge.
  - After release: level=0, no further frames, overflow_cnt=0.
- Saturation (CNT_W=2): 10 drops with the FIFO full -> overflow_cnt stays at 3.
